// File: rtl/io_map_pkg.sv
// Register offsets, STATUS bit layout and shared widths for the Titan I/O hub.
package io_map_pkg;

  localparam logic [3:0] IO_LED   = 4'h0;
  localparam logic [3:0] IO_SND   = 4'h1;
  localparam logic [3:0] IO_STAT  = 4'h2;
  localparam logic [3:0] IO_PAD   = 4'h3;
  localparam logic [3:0] IO_PRESS = 4'h4;

  localparam int unsigned STAT_OVF     = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_FULL    = 2;
  localparam int unsigned STAT_CNT_LSB = 3;
  localparam int unsigned STAT_CNT_W   = 5;

  localparam int unsigned PAD_W  = 8;
  localparam int unsigned RDATA_W = 32;

endpackage

// File: rtl/io_bus_hub_if.sv
// CPU data-bus, game-pad and sound-generator signals seen by the I/O hub.
interface io_bus_hub_if
  import io_map_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned N_PADS    = 4,
  parameter int unsigned SND_BITS  = 2
);

  logic                      en;
  logic                      memWrite;
  logic [WIDTH-1:0]          input_data;
  logic [ADDR_BITS-1:0]      address;
  logic [PAD_W*N_PADS-1:0]   pad_bits;
  logic [RDATA_W-1:0]        IO_Data;
  logic [WIDTH-1:0]          leds;
  logic [SND_BITS-1:0]       snd_data;
  logic                      snd_valid;
  logic                      snd_ready;

  modport master (
    output en, memWrite, input_data, address, pad_bits, snd_ready,
    input  IO_Data, leds, snd_data, snd_valid
  );

  modport slave (
    input  en, memWrite, input_data, address, pad_bits, snd_ready,
    output IO_Data, leds, snd_data, snd_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_bus_hub.sv
// Memory-mapped I/O hub: LED register, buffered sound commands, status and game-pad press tracking.
module io_bus_hub
  import io_map_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_BITS  = 14,
  parameter int unsigned N_PADS     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SND_BITS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  io_bus_hub_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PBITS = PAD_W * N_PADS;

  logic [3:0]          offset;
  logic                wr_c;
  logic                rd_c;
  logic                push_c;
  logic                pop_c;
  logic                press_rd_c;
  logic                ovf_event_c;
  logic                ovf_clr_c;
  logic [WIDTH-1:0]    leds_q;
  logic [RDATA_W-1:0]  rdata_q;
  logic [RDATA_W-1:0]  rdata_c;
  logic [RDATA_W-1:0]  stat_c;
  logic                ovf_q;
  logic [PBITS-1:0]    prev_pad_q;
  logic [PBITS-1:0]    flags_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                unused_addr_bits;

  assign offset           = bus.address[3:0];
  assign unused_addr_bits = ^bus.address[ADDR_BITS-1:4];
  assign wr_c             = bus.en & bus.memWrite;
  assign rd_c             = bus.en & ~bus.memWrite;
  assign push_c           = wr_c & (offset == IO_SND);
  assign pop_c            = bus.snd_valid & bus.snd_ready;
  assign press_rd_c       = rd_c & (offset == IO_PRESS);
  assign ovf_event_c      = push_c & fifo_full & ~pop_c;
  assign ovf_clr_c        = wr_c & (offset == IO_STAT) & bus.input_data[0];

  sync_fifo #(
    .DATA_W (SND_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_snd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (bus.input_data[SND_BITS-1:0]),
    .rdata (bus.snd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.snd_valid = ~fifo_empty;
  assign bus.leds      = leds_q;
  assign bus.IO_Data   = rdata_q;

  // Read mux; press flags are returned as they stand before the clearing edge.
  always_comb begin
    stat_c = '0;
    stat_c[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    stat_c[STAT_FULL]  = fifo_full;
    stat_c[STAT_EMPTY] = fifo_empty;
    stat_c[STAT_OVF]   = ovf_q;
    rdata_c = '0;
    case (offset)
      IO_LED:   rdata_c = RDATA_W'(leds_q);
      IO_STAT:  rdata_c = stat_c;
      IO_PAD:   rdata_c = RDATA_W'(bus.pad_bits);
      IO_PRESS: rdata_c = RDATA_W'(flags_q);
      default:  rdata_c = '0;
    endcase
  end

  // prev_pad resets to all ones so buttons held through reset are not seen as presses.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q     <= '0;
      rdata_q    <= '0;
      ovf_q      <= 1'b0;
      prev_pad_q <= '1;
      flags_q    <= '0;
    end else begin
      if (wr_c && offset == IO_LED) leds_q <= bus.input_data;
      if (rd_c) rdata_q <= rdata_c;
      ovf_q      <= (ovf_q & ~ovf_clr_c) | ovf_event_c;
      prev_pad_q <= bus.pad_bits;
      flags_q    <= (press_rd_c ? '0 : flags_q) | (bus.pad_bits & ~prev_pad_q);
    end
  end

endmodule

// File: tb/tb_io_bus_hub.sv
// Directed bench for io_bus_hub: LED, sound FIFO, status, pad press flags, reset and decode.
module tb_io_bus_hub;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ADDR_BITS  = 14;
  localparam int unsigned N_PADS     = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SND_BITS   = 2;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  io_bus_hub_if #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .N_PADS(N_PADS), .SND_BITS(SND_BITS)
  ) bus_if ();

  io_bus_hub #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .N_PADS(N_PADS),
    .FIFO_DEPTH(FIFO_DEPTH), .SND_BITS(SND_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [3:0] off, input logic [7:0] data);
    bus_if.en         = 1'b1;
    bus_if.memWrite   = 1'b1;
    bus_if.address    = ADDR_BITS'(off);
    bus_if.input_data = data;
    step();
    bus_if.en         = 1'b0;
    bus_if.memWrite   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off);
    bus_if.en       = 1'b1;
    bus_if.memWrite = 1'b0;
    bus_if.address  = ADDR_BITS'(off);
    step();
    bus_if.en       = 1'b0;
  endtask

  logic [1:0] exp_snd [4] = '{2'd3, 2'd2, 2'd1, 2'd2};

  initial begin
    reset             = 1'b1;
    bus_if.en         = 1'b0;
    bus_if.memWrite   = 1'b0;
    bus_if.input_data = '0;
    bus_if.address    = '0;
    bus_if.pad_bits   = '0;
    bus_if.snd_ready  = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    chk("reset_io_data", bus_if.IO_Data, 32'h0);
    chk("reset_leds", 32'(bus_if.leds), 32'h0);
    chk("reset_snd_valid", 32'(bus_if.snd_valid), 32'h0);
    chk("reset_snd_data", 32'(bus_if.snd_data), 32'h0);

    wr(4'h0, 8'hA5);
    chk("led_write", 32'(bus_if.leds), 32'hA5);
    rd(4'h0);
    chk("led_read", bus_if.IO_Data, 32'h0000_00A5);

    rd(4'h7);
    chk("decode_read_7", bus_if.IO_Data, 32'h0);
    wr(4'h7, 8'h3C);
    chk("decode_write_7_leds", 32'(bus_if.leds), 32'hA5);
    chk("decode_write_7_fifo", 32'(bus_if.snd_valid), 32'h0);
    rd(4'h1);
    chk("snd_cmd_reads_0", bus_if.IO_Data, 32'h0);

    wr(4'h1, 8'd1);
    chk("first_push_valid", 32'(bus_if.snd_valid), 32'h1);
    chk("first_push_data", 32'(bus_if.snd_data), 32'h1);
    wr(4'h1, 8'd3);
    wr(4'h1, 8'd2);
    wr(4'h1, 8'd1);
    wr(4'h1, 8'd3);
    rd(4'h2);
    chk("status_full_ovf", bus_if.IO_Data, 32'h25);
    wr(4'h2, 8'h01);
    rd(4'h2);
    chk("status_ovf_cleared", bus_if.IO_Data, 32'h24);

    bus_if.snd_ready = 1'b1;
    wr(4'h1, 8'd2);
    bus_if.snd_ready = 1'b0;
    chk("full_push_pop_head", 32'(bus_if.snd_data), 32'h3);
    rd(4'h2);
    chk("full_push_pop_status", bus_if.IO_Data, 32'h24);
    step();
    chk("head_stable_no_ready", 32'(bus_if.snd_data), 32'h3);

    bus_if.snd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid_%0d", i), 32'(bus_if.snd_valid), 32'h1);
      chk($sformatf("drain_data_%0d", i), 32'(bus_if.snd_data), 32'(exp_snd[i]));
      step();
    end
    chk("drained_valid", 32'(bus_if.snd_valid), 32'h0);
    bus_if.snd_ready = 1'b0;
    rd(4'h2);
    chk("status_empty", bus_if.IO_Data, 32'h02);

    bus_if.pad_bits = 32'h08;
    step();
    bus_if.pad_bits = 32'h00;
    step();
    rd(4'h4);
    chk("press_read", bus_if.IO_Data, 32'h08);
    rd(4'h4);
    chk("press_cleared", bus_if.IO_Data, 32'h0);

    bus_if.pad_bits = 32'h0000_0201;
    step();
    bus_if.pad_bits = 32'h0000_0211;
    rd(4'h4);
    chk("press_before_clear", bus_if.IO_Data, 32'h0000_0201);
    rd(4'h4);
    chk("press_survives_clear", bus_if.IO_Data, 32'h10);
    rd(4'h3);
    chk("pad_state", bus_if.IO_Data, 32'h0000_0211);

    bus_if.pad_bits = 32'hFF;
    wr(4'h1, 8'd1);
    wr(4'h1, 8'd2);
    wr(4'h1, 8'd3);
    wr(4'h0, 8'h5A);
    chk("pre_reset_valid", 32'(bus_if.snd_valid), 32'h1);
    reset = 1'b1;
    step();
    chk("reset_mid_valid", 32'(bus_if.snd_valid), 32'h0);
    chk("reset_mid_leds", 32'(bus_if.leds), 32'h0);
    chk("reset_mid_io_data", bus_if.IO_Data, 32'h0);
    reset = 1'b0;
    step();
    rd(4'h4);
    chk("held_through_reset_no_press", bus_if.IO_Data, 32'h0);
    rd(4'h2);
    chk("reset_status_empty", bus_if.IO_Data, 32'h02);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/io_bus_hub.md
Name: io_bus_hub

Overview:
Parametrised memory-mapped I/O hub for the Titan processor data bus. It decodes CPU loads and stores to an LED register, a sound-command FIFO, a status register, and N game-pad channels. It adds behaviour the earlier I/O decoder lacked:
- LED readback
- a buffered, handshaked sound-command path with overflow tracking
- per-pad sticky button-press (rising-edge) flags, cleared on read
- registered read data
NES_CONTROLLER instances and SoundGenerator stay external; this block connects to them through ports.

Parameters:
WIDTH, 8, CPU write-data width and LED register width (8..32)
ADDR_BITS, 14, CPU address width; only address[3:0] is decoded
N_PADS, 4, number of game-pad channels (1..4)
FIFO_DEPTH, 4, sound-command FIFO entries (power of 2, 2..16)
SND_BITS, 2, sound-command width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  bus access strobe for this I/O space
memWrite  in  1  1 = store, 0 = load (qualified by en)
input_data  in  WIDTH  CPU store data
address  in  ADDR_BITS  CPU address
pad_bits  in  8*N_PADS  held-button bytes from the pad controllers; pad k is bits [8k+7:8k]
IO_Data  out  32  registered read data
leds  out  WIDTH  LED register
snd_data  out  SND_BITS  head-of-FIFO sound command
snd_valid  out  1  FIFO not empty
snd_ready  in  1  sound generator accepts snd_data this cycle

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Values after reset:
  - IO_Data = 0, leds = 0
  - FIFO empty, so snd_valid = 0 and snd_data = 0
  - overflow = 0, press flags = 0
  - prev_pad = all ones, so buttons already held at reset do not flag a press
- Register map (address[3:0]); any other offset reads 0 and ignores writes:
  - 0x0 LED: read/write. Read returns leds zero-extended.
  - 0x1 SND_CMD: write only; pushes input_data[SND_BITS-1:0]. Reads return 0.
  - 0x2 STATUS: read returns {count[4:0] at bits 7:3, full at bit 2, empty at bit 1, overflow at bit 0}. Writing with input_data[0]=1 clears overflow.
  - 0x3 PAD_STATE: read returns pad_bits zero-extended to 32 bits.
  - 0x4 PAD_PRESS: read returns the sticky press flags, same layout as PAD_STATE, and clears them (read-to-clear).
- Write: takes effect on the clk edge when en & memWrite.
- Read: when en & !memWrite, IO_Data is updated at the next edge (1-cycle latency). Otherwise IO_Data holds its value.
- Press detection, every cycle:
  - new = pad_bits & ~prev_pad
  - prev_pad <= pad_bits
  - flags <= (read of PAD_PRESS ? 0 : flags) | new
  - A press arriving in the same cycle as a clearing read survives the clear.
  - The read returns the flag values as they were before that edge.
- Sound FIFO:
  - push = en & memWrite & (address[3:0] == 1)
  - pop = snd_valid & snd_ready
  - Push while full with no pop in the same cycle: the data is dropped, overflow is set, count is unchanged.
  - Push while full with a simultaneous pop: the push is accepted and count is unchanged.
  - Push and pop together when not full: count is unchanged and order is preserved.
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
  - snd_data is the head entry, stable while snd_valid & !snd_ready.
- Priority on overflow: if a clearing STATUS write and an overflow event occur in the same cycle, overflow ends up set.
- Reset mid-operation: the FIFO is flushed and any pending command is lost. snd_valid falls the cycle after reset is asserted.

Decomposition:
- Package io_map_pkg holds:
  - offset constants: IO_LED = 0, IO_SND = 1, IO_STAT = 2, IO_PAD = 3, IO_PRESS = 4
  - STATUS bit positions
  - the pad byte width (8)
- One natural sub-module: sync_fifo, parametrised by data width and depth, with push/pop/full/empty/count ports. It is instantiated once for the sound commands.
- Decode, LED logic, press logic and the read mux stay in io_bus_hub.

Test Plan:
- LED: reset, store 0xA5 to offset 0 -> leds = 0xA5 next cycle; load offset 0 -> IO_Data = 0x000000A5 one cycle later.
- FIFO fill: with snd_ready = 0, push commands 1,3,2,1,3 (FIFO_DEPTH = 4) -> fifth push dropped; STATUS reads count = 4, full = 1, overflow = 1. Store 1 to STATUS -> overflow = 0. Then snd_ready = 1 -> snd_data sequence 1,3,2,1, and snd_valid falls after the fourth pop.
- Full boundary: with the FIFO full, push 2 in the same cycle as a pop -> accepted, count stays 4, overflow stays 0, and 2 emerges last.
- Press flags: pad0 goes 0x00 -> 0x08 -> 0x00 -> PAD_PRESS read returns 0x00000008; an immediate second read returns 0. A new press in the same cycle as the clearing read is flagged on the next read.
- Reset behaviour: assert reset with 3 FIFO entries and pad_bits = 0xFF held -> snd_valid = 0, leds = 0; after release, PAD_PRESS reads 0 while the buttons stay held.
- Decode: load offset 0x7 -> IO_Data = 0; store to 0x7 -> no register changes.
